// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-port arbiter.
// The helper works on a fixed maximum width so one function serves every NUM_REQ.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 32;
  localparam int MAX_IDW = 5;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // Scan from ptr upward, wrapping at num; the lowest offset from ptr wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [MAX_IDW-1:0] ptr,
                                    input int                 num);
    pick_t res;
    int    cand;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < num) begin
        cand = int'(ptr) + k;
        if (cand >= num) cand = cand - num;
        if (valid[cand]) begin
          res.found = 1'b1;
          res.idx   = cand[MAX_IDW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-and-priority-encode: first valid requester at or after ptr_i.
// Supports up to fifo_arb_pkg::MAX_REQ requesters.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               found_o,
  output logic [IDW-1:0]     idx_o
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_IDW-1:0] ptr_ext;
  pick_t              pick;

  assign valid_ext = MAX_REQ'(valid_i);
  assign ptr_ext   = MAX_IDW'(ptr_i);
  assign pick      = rr_pick(valid_ext, ptr_ext, NUM_REQ);
  assign found_o   = pick.found;
  assign idx_o     = pick.idx[IDW-1:0];

  generate
    if (IDW < MAX_IDW) begin : g_hi
      logic unused_idx_hi;
      assign unused_idx_hi = ^pick.idx[MAX_IDW-1:IDW];
    end
  endgenerate

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NUM_REQ producers,
// with bounded bursts, almost_full throttling and a registered WEN/DIN stage.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int BURST_LEN  = 4,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int CW = $clog2(BURST_LEN + 1);

  arb_state_e            state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  accept;
  logic                  last_beat;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign cur_valid = req_valid[grant_q];
  assign cur_data  = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = (state_q == BURST) && cur_valid && !fifo_almost_full;
  assign last_beat = (burst_cnt_q == CW'(BURST_LEN - 1));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    wen_d       = 1'b0;
    din_d       = din_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        req_ready[grant_q] = !fifo_almost_full;
        if (accept) begin
          wen_d       = 1'b1;
          din_d       = cur_data;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        // A valid drop only ends the grant when we are not stalled.
        if ((accept && last_beat) || (!cur_valid && !fifo_almost_full)) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
          rr_ptr_d    = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      wen_q       <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      wen_q       <= wen_d;
      din_q       <= din_d;
    end
  end

  assign fifo_wen = wen_q;
  assign fifo_din = din_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a cycle-level reference of the
// arbitration rules, plus directed single-requester, reset and FIFO-fill scenarios.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int BL  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_almost_full = 1'b0;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_din;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wen         (fifo_wen),
    .fifo_din         (fifo_din),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: granted requester, beats taken this grant, next scan start.
  bit            m_busy;
  int            m_gid, m_ptr, m_cnt;
  bit            m_wen;
  logic [DW-1:0] m_din;
  logic [DW-1:0] sb[$];

  logic          last_wen;
  logic [DW-1:0] last_din;

  task automatic m_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_wen = 0; m_din = '0;
  endtask

  task automatic m_step();
    bit acc, found;
    int idx;
    if (!m_busy) begin
      m_wen = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1; m_gid = idx; m_cnt = 0; m_busy = 1;
        end
      end
    end else begin
      acc   = req_valid[m_gid] && !fifo_almost_full;
      m_wen = acc;
      if (acc) begin
        m_din = req_data[m_gid*DW +: DW];
        sb.push_back(m_din);
      end
      if ((acc && m_cnt == BL - 1) || (!req_valid[m_gid] && !fifo_almost_full)) begin
        m_busy = 0; m_cnt = 0; m_ptr = (m_gid + 1) % N;
      end else if (acc) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_regs();
    chk("fifo_wen", 64'(fifo_wen), 64'(m_wen));
    chk("fifo_din", 64'(fifo_din), 64'(m_din));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic check_ready();
    logic [N-1:0] exp;
    exp = '0;
    if (m_busy && !fifo_almost_full) exp[m_gid] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp));
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic af, input logic [N*DW-1:0] d);
    @(negedge clk);
    check_regs();
    last_wen = fifo_wen;
    last_din = fifo_din;
    req_valid = v;
    fifo_almost_full = af;
    req_data = d;
    #1;
    check_ready();
    m_step();
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Asynchronous assertion: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_wen"}, 64'(fifo_wen), 64'd0);
    chk({tag, "_din"}, 64'(fifo_din), 64'd0);
    chk({tag, "_grant"}, 64'(grant_id), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    m_reset();
    @(negedge clk);
    check_regs();
    rst_n = 1'b1;
    #1;
    check_ready();
    m_step();
  endtask

  initial begin
    logic [8:0]    pattern;
    logic [DW-1:0] words[$];
    logic [N-1:0]  v;
    int            idx, fcount, guard;
    bit            af, hit;
    logic [DW-1:0] fifo_q[$];

    m_reset();
    #2;
    do_reset("rst_init");

    // Single requester, eight sequential words.
    pattern = '0;
    idx = 0;
    for (int j = 0; j < 14; j++) begin
      logic [N*DW-1:0] d;
      d = '0;
      d[DW-1:0] = DW'(idx + 1);
      cycle((idx < 8) ? 4'b0001 : 4'b0000, 1'b0, d);
      if (j >= 2 && j <= 10) pattern[10-j] = last_wen;
      if (last_wen) words.push_back(last_din);
      if (req_ready[0] && req_valid[0]) idx++;
    end
    chk("single_wen_pattern", 64'(pattern), 64'(9'b111101111));
    chk("single_word_count", 64'(words.size()), 64'd8);
    for (int k = 0; k < 8 && k < words.size(); k++) chk("single_word_order", 64'(words[k]), 64'(k + 1));

    // Randomized traffic with sticky valids and sporadic almost_full.
    v = '0;
    for (int j = 0; j < 3000; j++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) < 2) v[i] = ~v[i];
      if (j % 500 < 60) v = '1;
      af = ($urandom_range(0, 99) < 15);
      cycle(v, af, rand_data());
    end

    // Reset in the middle of a burst; first grant afterwards must be requester 0.
    guard = 0;
    hit = 0;
    while (!hit && guard < 20) begin
      cycle('1, 1'b0, rand_data());
      guard++;
      if (m_busy && m_cnt == 1) hit = 1;
    end
    chk("rst_mid_reached", 64'(hit), 64'd1);
    do_reset("rst_mid");
    cycle('1, 1'b0, rand_data());
    chk("rst_first_grant", 64'(grant_id), 64'd0);
    chk("rst_first_busy", 64'(busy), 64'd1);

    // Fill a modelled DEPTH=32 / threshold=30 FIFO with no reads.
    req_valid = '0;
    fifo_almost_full = 1'b0;
    do_reset("rst_fifo");
    sb.delete();
    fcount = 0;
    for (int j = 0; j < 80; j++) begin
      af = (fcount >= 30);
      cycle('1, af, rand_data());
      if (last_wen) begin
        chk("fifo_no_write_full", 64'(fcount >= 32), 64'd0);
        fcount++;
        fifo_q.push_back(last_din);
      end
    end
    chk("fifo_stop_level", 64'(fcount == 30 || fcount == 31), 64'd1);
    chk("fifo_sb_size", 64'(fifo_q.size()), 64'(sb.size()));
    for (int k = 0; k < fifo_q.size() && k < sb.size(); k++) chk("fifo_content", 64'(fifo_q[k]), 64'(sb[k]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
